// File: rtl/status_report_scheduler_if.sv
// rtl/status_report_scheduler_if.sv - UART TX byte handshake (tx_data/tx_valid/tx_ready)
interface status_report_scheduler_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/status_report_scheduler.sv
// rtl/status_report_scheduler.sv - arbitrates status/ack frames onto the UART TX byte stream
// Optional trailing status checksum byte: define STATUS_CHECKSUM_EN.
module status_report_scheduler #(
    parameter int unsigned REPORT_PERIOD = 4,
    parameter logic [7:0]  HEADER_BYTE   = 8'hA5,
    parameter logic [7:0]  ACK_BYTE      = 8'h06
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             second,
    input  logic                             report_req,
    input  logic                             ack_req,
    input  logic [7:0]                       ack_code,
    input  logic [4:0]                       hunger,
    input  logic [4:0]                       happiness,
    input  logic [4:0]                       health,
    input  logic [4:0]                       hygiene,
    input  logic [4:0]                       energy,
    input  logic [4:0]                       social,
    input  logic                             is_sleeping,
    status_report_scheduler_if.master        tx,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             dropped_ack
);

`ifdef STATUS_CHECKSUM_EN
    localparam logic [3:0] STATUS_LAST = 4'd8;
`else
    localparam logic [3:0] STATUS_LAST = 4'd7;
`endif
    localparam logic [3:0] ACK_LAST    = 4'd1;
    localparam logic [7:0] PERIOD_LAST = 8'(REPORT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            rpt_pend_q, rpt_pend_d;
    logic            ack_pend_q, ack_pend_d;
    logic [7:0]      ack_code_q, ack_code_d;
    logic            is_ack_q, is_ack_d;
    logic [7:0]      frame_code_q, frame_code_d;
    logic [5:0][4:0] snap_q, snap_d;
    logic            snap_sleep_q, snap_sleep_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            dropped_q, dropped_d;

    logic            grant_ack, grant_rpt, period_hit;
    logic [3:0]      next_idx;
    logic [7:0]      status_next;

    assign grant_ack  = (state_q == IDLE) && ack_pend_q;
    assign grant_rpt  = (state_q == IDLE) && !ack_pend_q && rpt_pend_q;
    assign period_hit = second && (REPORT_PERIOD != 0) && (cnt_q == PERIOD_LAST);
    assign next_idx   = idx_q + 4'd1;

    // Status bytes after the header always come from the snapshot, never live stats.
    always_comb begin
        status_next = 8'h00;
        case (next_idx)
            4'd1:    status_next = {3'b000, snap_q[0]};
            4'd2:    status_next = {3'b000, snap_q[1]};
            4'd3:    status_next = {3'b000, snap_q[2]};
            4'd4:    status_next = {3'b000, snap_q[3]};
            4'd5:    status_next = {3'b000, snap_q[4]};
            4'd6:    status_next = {3'b000, snap_q[5]};
            4'd7:    status_next = {7'b0000000, snap_sleep_q};
`ifdef STATUS_CHECKSUM_EN
            4'd8:    status_next = {3'b000, snap_q[0] ^ snap_q[1] ^ snap_q[2] ^
                                            snap_q[3] ^ snap_q[4] ^ snap_q[5]} ^
                                   {7'b0000000, snap_sleep_q};
`endif
            default: status_next = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rpt_pend_d   = rpt_pend_q;
        ack_pend_d   = ack_pend_q;
        ack_code_d   = ack_code_q;
        is_ack_d     = is_ack_q;
        frame_code_d = frame_code_q;
        snap_d       = snap_q;
        snap_sleep_d = snap_sleep_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        dropped_d    = 1'b0;

        if (second) begin
            cnt_d = period_hit ? 8'd0 : cnt_q + 8'd1;
        end

        // A new set in the grant cycle wins so it yields one further frame.
        if (grant_rpt) rpt_pend_d = 1'b0;
        if (report_req || period_hit) rpt_pend_d = 1'b1;

        if (grant_ack) ack_pend_d = 1'b0;
        if (ack_req) begin
            if (ack_pend_q && !grant_ack) begin
                dropped_d = 1'b1;
            end else begin
                ack_pend_d = 1'b1;
                ack_code_d = ack_code;
            end
        end

        case (state_q)
            IDLE: begin
                if (grant_ack) begin
                    is_ack_d     = 1'b1;
                    frame_code_d = ack_code_q;
                    state_d      = SNAP;
                end else if (grant_rpt) begin
                    is_ack_d = 1'b0;
                    state_d  = SNAP;
                end
            end
            SNAP: begin
                if (!is_ack_q) begin
                    snap_d       = {social, energy, hygiene, health, happiness, hunger};
                    snap_sleep_d = is_sleeping;
                end
                idx_d      = 4'd0;
                tx_data_d  = is_ack_q ? ACK_BYTE : HEADER_BYTE;
                tx_valid_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                if (tx.tx_ready) begin
                    if (idx_q == (is_ack_q ? ACK_LAST : STATUS_LAST)) begin
                        tx_valid_d   = 1'b0;
                        tx_data_d    = 8'h00;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d     = next_idx;
                        tx_data_d = is_ack_q ? frame_code_q : status_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            rpt_pend_q   <= 1'b0;
            ack_pend_q   <= 1'b0;
            ack_code_q   <= 8'h00;
            is_ack_q     <= 1'b0;
            frame_code_q <= 8'h00;
            snap_q       <= '0;
            snap_sleep_q <= 1'b0;
            idx_q        <= 4'd0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rpt_pend_q   <= rpt_pend_d;
            ack_pend_q   <= ack_pend_d;
            ack_code_q   <= ack_code_d;
            is_ack_q     <= is_ack_d;
            frame_code_q <= frame_code_d;
            snap_q       <= snap_d;
            snap_sleep_q <= snap_sleep_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
            dropped_q    <= dropped_d;
        end
    end

    assign tx.tx_data   = tx_data_q;
    assign tx.tx_valid  = tx_valid_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign dropped_ack  = dropped_q;

endmodule

// File: tb/tb_status_report_scheduler.sv
// tb/tb_status_report_scheduler.sv - directed self-checking bench for status_report_scheduler
module tb_status_report_scheduler;

`ifdef STATUS_CHECKSUM_EN
    localparam int SLEN = 9;
`else
    localparam int SLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       second = 1'b0;
    logic       report_req = 1'b0;
    logic       ack_req = 1'b0;
    logic [7:0] ack_code = 8'h00;
    logic [4:0] hunger = 0, happiness = 0, health = 0, hygiene = 0, energy = 0, social = 0;
    logic       is_sleeping = 1'b0;
    logic       busy, frame_done, dropped_ack;
    logic       busy2, frame_done2, dropped_ack2;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_log [$];
    int done_cnt = 0;
    int drop_cnt = 0;
    int dut2_activity = 0;

    status_report_scheduler_if tx_if ();
    status_report_scheduler_if tx_if2 ();

    status_report_scheduler dut (
        .clk(clk), .reset(reset), .second(second), .report_req(report_req),
        .ack_req(ack_req), .ack_code(ack_code),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .is_sleeping(is_sleeping), .tx(tx_if),
        .busy(busy), .frame_done(frame_done), .dropped_ack(dropped_ack)
    );

    status_report_scheduler #(.REPORT_PERIOD(0)) dut_noper (
        .clk(clk), .reset(reset), .second(second), .report_req(1'b0),
        .ack_req(1'b0), .ack_code(8'h00),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .social(social),
        .is_sleeping(is_sleeping), .tx(tx_if2),
        .busy(busy2), .frame_done(frame_done2), .dropped_ack(dropped_ack2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_if.tx_valid && tx_if.tx_ready) rx_log.push_back(tx_if.tx_data);
        if (frame_done)  done_cnt <= done_cnt + 1;
        if (dropped_ack) drop_cnt <= drop_cnt + 1;
        if (tx_if2.tx_valid || frame_done2 || busy2) dut2_activity <= dut2_activity + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; second = 1'b0; report_req = 1'b0; ack_req = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse_second;
        second = 1'b1;
        tick(1);
        second = 1'b0;
    endtask

    task automatic set_stats_case1;
        hunger = 5'd5; happiness = 5'd10; health = 5'd31;
        hygiene = 5'd0; energy = 5'd7; social = 5'd12; is_sleeping = 1'b1;
    endtask

    task automatic wait_log(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && rx_log.size() < target; i++) tick(1);
        ok = (rx_log.size() >= target);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        for (int i = 0; i < budget && !tx_if.tx_valid; i++) tick(1);
        ok = tx_if.tx_valid;
    endtask

    function automatic logic [7:0] status_byte(input int i);
        case (i)
            0: return 8'hA5;
            1: return {3'b000, hunger};
            2: return {3'b000, happiness};
            3: return {3'b000, health};
            4: return {3'b000, hygiene};
            5: return {3'b000, energy};
            6: return {3'b000, social};
            7: return {7'b0, is_sleeping};
            default: return {3'b000, hunger ^ happiness ^ health ^ hygiene ^ energy ^ social}
                            ^ {7'b0, is_sleeping};
        endcase
    endfunction

    task automatic test_reset;
        do_reset();
        checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_if.tx_valid); end
        checks++; if (tx_if.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_if.tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (dropped_ack !== 1'b0) begin failures++; $display("FAIL reset_dropped_ack got=%b exp=0", dropped_ack); end
    endtask

    task automatic test_periodic_status;
        logic [7:0] exp1 [9] = '{8'hA5, 8'h05, 8'h0A, 8'h1F, 8'h00, 8'h07, 8'h0C, 8'h01, 8'h1A};
        int base, d0;
        bit ok;
        do_reset();
        set_stats_case1();
        tx_if.tx_ready = 1'b1;
        base = rx_log.size(); d0 = done_cnt;
        repeat (3) begin
            pulse_second();
            tick(2);
        end
        checks++; if (tx_if.tx_valid !== 1'b0 || rx_log.size() != base) begin failures++; $display("FAIL period_early valid=%b bytes=%0d exp no frame", tx_if.tx_valid, rx_log.size() - base); end
        second = 1'b1;
        tick(1);
        second = 1'b0;
        tick(1);
        checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL latency_n2 got=%b exp=0", tx_if.tx_valid); end
        tick(1);
        checks++; if (tx_if.tx_valid !== 1'b1) begin failures++; $display("FAIL latency_n3 got=%b exp=1", tx_if.tx_valid); end
        wait_log(base + SLEN, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL periodic_timeout got=%0d bytes exp=%0d", rx_log.size() - base, SLEN); end
        tick(3);
        for (int i = 0; i < SLEN; i++) begin
            checks++; if (rx_log[base + i] !== exp1[i]) begin failures++; $display("FAIL periodic_byte%0d got=%h exp=%h", i, rx_log[base + i], exp1[i]); end
        end
        checks++; if (rx_log.size() != base + SLEN) begin failures++; $display("FAIL periodic_len got=%0d exp=%0d", rx_log.size() - base, SLEN); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL periodic_frame_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL periodic_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp [9];
        int base, d0;
        bit ok;
        do_reset();
        set_stats_case1();
        tx_if.tx_ready = 1'b0;
        base = rx_log.size(); d0 = done_cnt;
        for (int i = 0; i < SLEN; i++) exp[i] = status_byte(i);
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_start_timeout got=%b exp=1", tx_if.tx_valid); end
        tx_if.tx_ready = 1'b1;
        tick(3);
        tx_if.tx_ready = 1'b0;
        hunger = 5'd1; happiness = 5'd2; health = 5'd3; hygiene = 5'd4;
        energy = 5'd5; social = 5'd6; is_sleeping = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++; if ({tx_if.tx_valid, tx_if.tx_data} !== {1'b1, 8'h1F}) begin failures++; $display("FAIL bp_hold_cycle%0d got=%b/%h exp=1/1f", c, tx_if.tx_valid, tx_if.tx_data); end
            tick(1);
        end
        tx_if.tx_ready = 1'b1;
        wait_log(base + SLEN, 40, ok);
        tick(3);
        checks++; if (rx_log.size() != base + SLEN) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", rx_log.size() - base, SLEN); end
        for (int i = 0; i < SLEN; i++) begin
            checks++; if (rx_log[base + i] !== exp[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, rx_log[base + i], exp[i]); end
        end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL bp_frame_done got=%0d exp=1", done_cnt - d0); end
        set_stats_case1();
    endtask

    task automatic test_ack_during_status;
        int base, d0, dr0;
        bit ok;
        do_reset();
        tx_if.tx_ready = 1'b1;
        base = rx_log.size(); d0 = done_cnt; dr0 = drop_cnt;
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
        wait_valid(10, ok);
        ack_req = 1'b1; ack_code = 8'h31;
        tick(1);
        ack_req = 1'b0;
        tick(1);
        ack_req = 1'b1; ack_code = 8'h32;
        tick(1);
        ack_req = 1'b0; ack_code = 8'h00;
        checks++; if (dropped_ack !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", dropped_ack); end
        tick(1);
        checks++; if (dropped_ack !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%b exp=0", dropped_ack); end
        wait_log(base + SLEN + 2, 60, ok);
        tick(20);
        checks++; if (rx_log.size() != base + SLEN + 2) begin failures++; $display("FAIL ack_len got=%0d exp=%0d", rx_log.size() - base, SLEN + 2); end
        for (int i = 0; i < SLEN; i++) begin
            checks++; if (rx_log[base + i] !== status_byte(i)) begin failures++; $display("FAIL ack_status_byte%0d got=%h exp=%h", i, rx_log[base + i], status_byte(i)); end
        end
        checks++; if (rx_log[base + SLEN] !== 8'h06) begin failures++; $display("FAIL ack_hdr got=%h exp=06", rx_log[base + SLEN]); end
        checks++; if (rx_log[base + SLEN + 1] !== 8'h31) begin failures++; $display("FAIL ack_code got=%h exp=31", rx_log[base + SLEN + 1]); end
        checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL ack_frame_done got=%0d exp=2", done_cnt - d0); end
        checks++; if (drop_cnt - dr0 != 1) begin failures++; $display("FAIL ack_drop_count got=%0d exp=1", drop_cnt - dr0); end
    endtask

    task automatic test_ack_priority;
        int base, d0;
        bit ok;
        do_reset();
        tx_if.tx_ready = 1'b1;
        base = rx_log.size(); d0 = done_cnt;
        repeat (3) begin
            pulse_second();
            tick(1);
        end
        ack_req = 1'b1; ack_code = 8'h44; report_req = 1'b1;
        tick(1);
        ack_req = 1'b0; report_req = 1'b0; ack_code = 8'h00;
        wait_log(base + 3, 40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL prio_timeout got=%0d bytes exp>=3", rx_log.size() - base); end
        report_req = 1'b1;
        tick(2);
        second = 1'b1;
        tick(1);
        report_req = 1'b0; second = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_in_frame got=%b exp=1", busy); end
        wait_log(base + 2 + 2 * SLEN, 80, ok);
        tick(30);
        checks++; if (rx_log.size() != base + 2 + 2 * SLEN) begin failures++; $display("FAIL prio_len got=%0d exp=%0d", rx_log.size() - base, 2 + 2 * SLEN); end
        checks++; if ({rx_log[base], rx_log[base + 1]} !== 16'h0644) begin failures++; $display("FAIL prio_ack_first got=%h%h exp=0644", rx_log[base], rx_log[base + 1]); end
        for (int i = 0; i < 2 * SLEN; i++) begin
            checks++; if (rx_log[base + 2 + i] !== status_byte(i % SLEN)) begin failures++; $display("FAIL prio_status_byte%0d got=%h exp=%h", i, rx_log[base + 2 + i], status_byte(i % SLEN)); end
        end
        checks++; if (done_cnt - d0 != 3) begin failures++; $display("FAIL prio_frame_done got=%0d exp=3", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        bit ok;
        do_reset();
        tx_if.tx_ready = 1'b0;
        pulse_second();
        tick(1);
        pulse_second();
        tick(1);
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
        wait_valid(10, ok);
        tx_if.tx_ready = 1'b1;
        tick(4);
        tx_if.tx_ready = 1'b0;
        checks++; if ({tx_if.tx_valid, tx_if.tx_data} !== {1'b1, status_byte(4)}) begin failures++; $display("FAIL rst_byte4 got=%b/%h exp=1/%h", tx_if.tx_valid, tx_if.tx_data, status_byte(4)); end
        ack_req = 1'b1; ack_code = 8'h55; report_req = 1'b1;
        tick(1);
        ack_req = 1'b0; report_req = 1'b0;
        reset = 1'b1;
        tick(1);
        checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", tx_if.tx_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        reset = 1'b0;
        tx_if.tx_ready = 1'b1;
        base = rx_log.size();
        tick(20);
        checks++; if (rx_log.size() != base || busy !== 1'b0) begin failures++; $display("FAIL rst_no_pending got=%0d bytes busy=%b exp=0/0", rx_log.size() - base, busy); end
        repeat (3) begin
            pulse_second();
            tick(2);
        end
        tick(3);
        checks++; if (rx_log.size() != base) begin failures++; $display("FAIL rst_counter_restart got=%0d bytes exp=0", rx_log.size() - base); end
        pulse_second();
        wait_log(base + SLEN, 30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_fourth_second got=%0d bytes exp=%0d", rx_log.size() - base, SLEN); end
        checks++; if (rx_log[base] !== 8'hA5) begin failures++; $display("FAIL rst_restart_hdr got=%h exp=a5", rx_log[base]); end
        tick(5);
    endtask

    task automatic test_period_disabled;
        repeat (20) begin
            pulse_second();
            tick(1);
        end
        tick(5);
        checks++; if (dut2_activity != 0) begin failures++; $display("FAIL period0_activity got=%0d exp=0", dut2_activity); end
        checks++; if (tx_if2.tx_valid !== 1'b0) begin failures++; $display("FAIL period0_valid got=%b exp=0", tx_if2.tx_valid); end
    endtask

    initial begin
        tx_if.tx_ready  = 1'b1;
        tx_if2.tx_ready = 1'b1;
        set_stats_case1();
        test_reset();
        test_periodic_status();
        test_backpressure();
        test_ack_during_status();
        test_ack_priority();
        test_reset_mid_frame();
        test_period_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
